// File: rtl/restoring_divider8_pkg.sv
// Shared definitions for the restoring divider: default width and FSM state encoding.
package restoring_divider8_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } div_state_e;

endpackage

// File: rtl/restoring_divider8_trial_sub.sv
// Trial subtractor: a - b computed as a + ~b + 1, borrow is the inverted carry-out.
module restoring_divider8_trial_sub #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] sum;

  // Extend by one bit so the carry-out of the adder is visible.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    diff   = sum[W-1:0];
    borrow = ~sum[W];
  end

endmodule

// File: rtl/restoring_divider8.sv
// Sequential unsigned restoring divider: one trial subtraction per cycle under a
// start/ready/done handshake. Zero divisor short-circuits straight to DONE.
module restoring_divider8
  import restoring_divider8_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_d, rem_d;
  logic             dz_d;

  logic [WIDTH:0]   t_a, t_b, t_diff;
  logic             t_borrow;

  // Partial remainder shifted left with the next dividend bit, against the divisor.
  always_comb begin
    t_a = {r_q, q_q[WIDTH-1]};
    t_b = {1'b0, d_q};
  end

  restoring_divider8_trial_sub #(
    .W (WIDTH + 1)
  ) u_trial_sub (
    .a      (t_a),
    .b      (t_b),
    .diff   (t_diff),
    .borrow (t_borrow)
  );

  // Handshake outputs decoded directly from the state register.
  always_comb begin
    ready = (state_q == StIdle);
    done  = (state_q == StDone);
  end

  // Next-state, datapath and result-register logic.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quotient;
    rem_d   = remainder;
    dz_d    = div_by_zero;
    case (state_q)
      StIdle: begin
        if (start) begin
          q_d   = dividend;
          d_d   = divisor;
          r_d   = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d = StDone;
            quot_d  = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (!t_borrow) begin
          r_d = t_diff[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CntW'(1);
        // Last iteration: capture this cycle's Q/R so the result lands with DONE.
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
          quot_d  = q_d;
          rem_d   = r_d;
          dz_d    = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, working registers and held results; async reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      r_q         <= r_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient    <= quot_d;
      remainder   <= rem_d;
      div_by_zero <= dz_d;
    end
  end

endmodule

// File: tb/tb_restoring_divider8.sv
// Scoreboard bench for restoring_divider8: stimulus pushes expected results, a monitor
// pops and checks them (value and latency) whenever done is seen.
module tb_restoring_divider8;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       ready;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc;
  int   last_acc;
  int   prev_acc;
  int   n_checks;
  int   n_fail;

  restoring_divider8 #(
    .WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Cycle counter and accept tracker; sees pre-edge values since the DUT updates via NBA.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && start && ready) begin
      acc_q.push_back(cyc);
      prev_acc = last_acc;
      last_acc = cyc;
    end
  end

  // Monitor: compare each done against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        int   a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("div_by_zero", int'(div_by_zero), int'(e.dz));
        chk("latency", cyc - a, e.dz ? 0 : 8);
        chk("ready_in_done", int'(ready), 0);
      end
    end
  end

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                       input logic [7:0] er, input logic edz);
    wait_ready();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back('{q: eq, r: er, dz: edz});
    @(negedge clk);
    start    = 1'b0;
    // Scramble operands; they must not affect the operation in flight.
    dividend = 8'h5A;
    divisor  = 8'h00;
  endtask

  initial begin
    cyc      = 0;
    last_acc = 0;
    prev_acc = 0;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    issue(8'd0, 8'd3, 8'd0, 8'd0, 1'b0);
    issue(8'd77, 8'd0, 8'd255, 8'd77, 1'b1);
    issue(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);

    // Start pulsed mid-operation must be ignored.
    issue(8'd100, 8'd9, 8'd11, 8'd1, 1'b0);
    @(negedge clk);
    chk("busy_ready", int'(ready), 0);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;

    // Reset in the middle of 200/7 aborts with no done pulse.
    issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_dbz", int'(div_by_zero), 0);
    chk("abort_ready", int'(ready), 1);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'd13, 8'd4, 8'd3, 8'd1, 1'b0);

    // Back-to-back with start held high.
    wait_ready();
    dividend = 8'd255;
    divisor  = 8'd16;
    start    = 1'b1;
    exp_q.push_back('{q: 8'd15, r: 8'd15, dz: 1'b0});
    @(negedge clk);
    dividend = 8'd128;
    divisor  = 8'd3;
    exp_q.push_back('{q: 8'd42, r: 8'd2, dz: 1'b0});
    @(negedge clk);
    wait_ready();
    @(negedge clk);
    start = 1'b0;
    chk("b2b_period", last_acc - prev_acc, 10);

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
